// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU encodings, binary32 constants and rounding-increment helper
package FPU_pkg;

    localparam logic [2:0] FPU_RM_RNE = 3'b000;
    localparam logic [2:0] FPU_RM_RTZ = 3'b001;
    localparam logic [2:0] FPU_RM_RDN = 3'b010;
    localparam logic [2:0] FPU_RM_RUP = 3'b011;
    localparam logic [2:0] FPU_RM_RMM = 3'b100;

    // bit positions inside fflags = {NV,DZ,OF,UF,NX}
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_MAXF = 32'h7F7F_FFFF;
    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

    // Round-up decision; the reserved encodings fall back to nearest-even.
    function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                       input logic lsb, input logic r, input logic s);
        logic inc;
        case (rm)
            FPU_RM_RTZ: inc = 1'b0;
            FPU_RM_RDN: inc = (r | s) & sgn;
            FPU_RM_RUP: inc = (r | s) & ~sgn;
            FPU_RM_RMM: inc = r;
            default:    inc = r & (s | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/rshifter.sv
// rtl/rshifter.sv - right shifter with fill-bit select and sticky OR of the bits shifted out
module rshifter #(
    parameter int WIDTH = 26,
    parameter int SEL_W = 5
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_sgn,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sticky
);

    logic [WIDTH-1:0] w_fill_mask;
    logic [WIDTH-1:0] w_out_mask;

    // Shifts at or beyond WIDTH make the masks saturate, so everything lands in sticky.
    always_comb begin
        w_fill_mask = ~({WIDTH{1'b1}} >> i_sel);
        w_out_mask  = ~({WIDTH{1'b1}} << i_sel);
        o_data      = (i_data >> i_sel) | (i_sgn ? w_fill_mask : '0);
        o_sticky    = |(i_data & w_out_mask);
    end

endmodule

// File: rtl/float_rounder.sv
// rtl/float_rounder.sv - binary32 denormalise/round/pack stage with 2-deep valid/ready pipeline
module float_rounder
    import FPU_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [23:0] man,
    input  logic [9:0]  exp,
    input  logic        sgn,
    input  logic        round_bit,
    input  logic        sticky_bit,
    input  logic        skip_round,
    input  logic        IV,
    input  logic [2:0]  rm,
    output logic [31:0] float_out,
    output logic [4:0]  fflags
);

    // stage-1 registers
    logic        r_s1_valid;
    logic [23:0] r_s1_man;
    logic [9:0]  r_s1_exp;
    logic        r_s1_sgn, r_s1_r, r_s1_s, r_s1_skip, r_s1_iv, r_s1_tiny;
    logic [2:0]  r_s1_rm;

    // stage-2 (output) registers
    logic        r_valid_out;
    logic [31:0] r_float_out;
    logic [4:0]  r_fflags;

    logic        w_s2_advance;
    logic        w_exp_le0, w_do_denorm, w_inc_norm, w_tiny;
    logic [10:0] w_shamt_full;
    logic [4:0]  w_shamt, w_sel;
    logic [25:0] w_sh_data;
    logic        w_sh_sticky;

    logic        w_inc, w_ovf, w_ovf_inf, w_nx;
    logic [24:0] w_mant25;
    logic [23:0] w_mant;
    logic [10:0] w_exp_ext, w_exp_r;
    logic [31:0] w_float;
    logic [4:0]  w_flags;

    assign w_s2_advance = !r_valid_out || ready_in;
    assign ready_out    = !r_s1_valid || w_s2_advance;
    assign valid_out    = r_valid_out;
    assign float_out    = r_float_out;
    assign fflags       = r_fflags;

    // Stage 1: subnormal shift amount (saturated) and tininess judged at normal precision.
    always_comb begin
        w_exp_le0    = exp[9] || (exp == 10'd0);
        w_do_denorm  = !skip_round && w_exp_le0;
        w_shamt_full = 11'd1 - {exp[9], exp};
        w_shamt      = (w_shamt_full > 11'd26) ? 5'd26 : w_shamt_full[4:0];
        w_sel        = w_do_denorm ? w_shamt : 5'd0;
        w_inc_norm   = round_inc(rm, sgn, man[0], round_bit, sticky_bit);
        w_tiny       = !skip_round && (man != 24'd0) &&
                       (exp[9] || ((exp == 10'd0) && !((man == 24'hFFFFFF) && w_inc_norm)));
    end

    // A trailing zero pad bit keeps the round bit out of sticky for the first position shifted.
    rshifter #(.WIDTH(26), .SEL_W(5)) u_rshifter (
        .i_data   ({man, round_bit, 1'b0}),
        .i_sel    (w_sel),
        .i_sgn    (1'b0),
        .o_data   (w_sh_data),
        .o_sticky (w_sh_sticky)
    );

    // Stage 2: increment, carry-out renormalisation, overflow saturation and packing.
    always_comb begin
        w_inc     = round_inc(r_s1_rm, r_s1_sgn, r_s1_man[0], r_s1_r, r_s1_s);
        w_mant25  = {1'b0, r_s1_man} + {24'd0, w_inc};
        w_exp_ext = {r_s1_exp[9], r_s1_exp};
        w_mant    = w_mant25[23:0];
        w_exp_r   = w_exp_ext;
        if (w_mant25[24]) begin
            w_mant  = 24'h800000;
            w_exp_r = w_exp_ext + 11'd1;
        end else if ((w_exp_ext == 11'd0) && w_mant25[23]) begin
            w_exp_r = 11'd1;
        end
        w_ovf     = !w_exp_r[10] && (w_exp_r >= 11'd255);
        w_ovf_inf = !(r_s1_rm == FPU_RM_RTZ) &&
                    !((r_s1_rm == FPU_RM_RUP) && r_s1_sgn) &&
                    !((r_s1_rm == FPU_RM_RDN) && !r_s1_sgn);
        w_nx      = r_s1_r || r_s1_s;

        w_flags                = 5'd0;
        w_flags[FFLAG_NV]      = r_s1_iv;
        if (r_s1_skip) begin
            w_float = {r_s1_sgn, r_s1_exp[7:0], r_s1_man[22:0]};
        end else begin
            w_flags[FFLAG_OF] = w_ovf;
            w_flags[FFLAG_UF] = r_s1_tiny && w_nx;
            w_flags[FFLAG_NX] = w_nx || w_ovf;
            if (w_ovf)
                w_float = {r_s1_sgn, w_ovf_inf ? FP32_INF[30:0] : FP32_MAXF[30:0]};
            else if (w_mant == 24'd0)
                w_float = {r_s1_sgn, 31'd0};
            else
                w_float = {r_s1_sgn, w_exp_r[7:0], w_mant[22:0]};
        end
    end

    // Stage-1 register: loads whenever it is empty or its content moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_man   <= '0;
            r_s1_exp   <= '0;
            r_s1_sgn   <= 1'b0;
            r_s1_r     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_skip  <= 1'b0;
            r_s1_iv    <= 1'b0;
            r_s1_tiny  <= 1'b0;
            r_s1_rm    <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (ready_out) begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_man  <= w_sh_data[25:2];
                r_s1_r    <= w_sh_data[1];
                r_s1_s    <= sticky_bit | w_sh_data[0] | w_sh_sticky;
                r_s1_exp  <= w_do_denorm ? 10'd0 : exp;
                r_s1_sgn  <= sgn;
                r_s1_skip <= skip_round;
                r_s1_iv   <= IV;
                r_s1_tiny <= w_tiny;
                r_s1_rm   <= rm;
            end
        end
    end

    // Output register: holds while the writeback stalls a valid result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_float_out <= '0;
            r_fflags    <= '0;
        end else if (flush) begin
            r_valid_out <= 1'b0;
            r_float_out <= '0;
            r_fflags    <= '0;
        end else if (w_s2_advance) begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_float_out <= w_float;
                r_fflags    <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_float_rounder.sv
// tb/tb_float_rounder.sv - directed table and pipeline-sequence bench for float_rounder
module tb_float_rounder;

    logic        clk = 1'b0;
    logic        reset, flush, valid_in, ready_in;
    logic        ready_out, valid_out;
    logic [23:0] man;
    logic [9:0]  exp;
    logic        sgn, round_bit, sticky_bit, skip_round, IV;
    logic [2:0]  rm;
    logic [31:0] float_out;
    logic [4:0]  fflags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    float_rounder dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .man        (man),
        .exp        (exp),
        .sgn        (sgn),
        .round_bit  (round_bit),
        .sticky_bit (sticky_bit),
        .skip_round (skip_round),
        .IV         (IV),
        .rm         (rm),
        .float_out  (float_out),
        .fflags     (fflags)
    );

    typedef struct {
        logic [23:0] man;
        logic [9:0]  exp;
        logic        sgn, r, s, skip, iv;
        logic [2:0]  rm;
        logic [31:0] f;
        logic [4:0]  fl;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic drive_vec(input int i);
        man        = vt[i].man;
        exp        = vt[i].exp;
        sgn        = vt[i].sgn;
        round_bit  = vt[i].r;
        sticky_bit = vt[i].s;
        skip_round = vt[i].skip;
        IV         = vt[i].iv;
        rm         = vt[i].rm;
    endtask

    int ids[4] = '{0, 3, 7, 9};

    initial begin
        //          man        exp      sgn  r     s     skip  iv    rm      float         flags
        vt[0]  = '{24'h800000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'h00};
        vt[1]  = '{24'h800001, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h3F800002, 5'h01};
        vt[2]  = '{24'h800001, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h3F800001, 5'h01};
        vt[3]  = '{24'hFFFFFF, 10'd127, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h40000000, 5'h01};
        vt[4]  = '{24'hFFFFFF, 10'd254, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h7F800000, 5'h05};
        vt[5]  = '{24'hFFFFFF, 10'd254, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h01};
        vt[6]  = '{24'hFFFFFF, 10'd255, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h05};
        vt[7]  = '{24'h800000, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00200000, 5'h00};
        vt[8]  = '{24'h800000, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h00200001, 5'h03};
        vt[9]  = '{24'hC00000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h7FC00000, 5'h10};
        vt[10] = '{24'hFFFFFF, 10'd254, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 32'hFF800000, 5'h05};
        vt[11] = '{24'h800000, 10'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'hFF7FFFFF, 5'h05};
        vt[12] = '{24'h800000, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'h3F800001, 5'h01};
        vt[13] = '{24'h800000, 10'd127, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 32'h3F800000, 5'h01};
        vt[14] = '{24'h000000, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h80000000, 5'h00};
        vt[15] = '{24'h800000, 10'h39C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 32'h00000001, 5'h03};
        vt[16] = '{24'hFFFFFF, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00800000, 5'h01};
        vt[17] = '{24'hFFFFFF, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h007FFFFF, 5'h03};

        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        drive_vec(0);
        repeat (2) @(negedge clk);
        check("reset_valid_out", {31'd0, valid_out}, 32'd0);
        check("reset_float_out", float_out, 32'd0);
        check("reset_fflags", {27'd0, fflags}, 32'd0);
        check("reset_ready_out", {31'd0, ready_out}, 32'd1);
        reset = 1'b0;

        // single results with latency measurement
        for (int i = 0; i < 18; i++) begin
            int cnt;
            @(negedge clk);
            drive_vec(i);
            valid_in = 1'b1;
            ready_in = 1'b1;
            #1;
            check($sformatf("v%0d_ready", i), {31'd0, ready_out}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            valid_in = 1'b0;
            cnt = 1;
            while (!valid_out && cnt < 8) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("v%0d_latency", i), cnt, 2);
            check($sformatf("v%0d_float", i), float_out, vt[i].f);
            check($sformatf("v%0d_flags", i), {27'd0, fflags}, {27'd0, vt[i].fl});
        end
        repeat (2) @(negedge clk);

        // streaming with a 3-cycle writeback stall
        begin
            int sent = 0, got = 0;
            logic acc, stalled_prev = 1'b0, saw_low = 1'b0;
            logic [31:0] held_f;
            logic [4:0]  held_fl;
            held_f = '0; held_fl = '0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge clk);
                if (stalled_prev) begin
                    check("stall_hold_valid", {31'd0, valid_out}, 32'd1);
                    check("stall_hold_float", float_out, held_f);
                    check("stall_hold_flags", {27'd0, fflags}, {27'd0, held_fl});
                end
                if (valid_out && ready_in) begin
                    if (got < 4) begin
                        check($sformatf("stream%0d_float", got), float_out, vt[ids[got]].f);
                        check($sformatf("stream%0d_flags", got), {27'd0, fflags}, {27'd0, vt[ids[got]].fl});
                    end
                    got++;
                end
                held_f  = float_out;
                held_fl = fflags;
                ready_in = !(cyc >= 3 && cyc <= 5);
                if (sent < 4) begin
                    drive_vec(ids[sent]);
                    valid_in = 1'b1;
                end else begin
                    valid_in = 1'b0;
                end
                stalled_prev = valid_out && !ready_in;
                #1;
                if (!ready_out) saw_low = 1'b1;
                acc = valid_in && ready_out;
                @(posedge clk);
                if (acc) sent++;
            end
            check("stream_sent", sent, 4);
            check("stream_got", got, 4);
            check("stream_ready_dropped", {31'd0, saw_low}, 32'd1);
        end

        // flush while stalled with both stages full
        @(negedge clk);
        ready_in = 1'b0;
        drive_vec(0);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_vec(3);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        check("flush_pre_valid", {31'd0, valid_out}, 32'd1);
        check("flush_pre_float", float_out, vt[0].f);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid_out", {31'd0, valid_out}, 32'd0);
        check("flush_float_out", float_out, 32'd0);
        ready_in = 1'b1;
        repeat (3) @(negedge clk);
        check("flush_s1_cleared", {31'd0, valid_out}, 32'd0);

        // asynchronous reset with a result in flight
        drive_vec(1);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_midop_valid", {31'd0, valid_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
